// File: rtl/md4_pkg.sv
// MD4 shared definitions: IV, round constants,
// per-step message index and shift tables.
package md4_pkg;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hEFCDAB89;
    localparam logic [31:0] IV_C = 32'h98BADCFE;
    localparam logic [31:0] IV_D = 32'h10325476;

    localparam logic [31:0] K_F = 32'h00000000;
    localparam logic [31:0] K_G = 32'h5A827999;
    localparam logic [31:0] K_H = 32'h6ED9EBA1;

    localparam logic [5:0] LAST_STEP = 6'd48;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        RND_F,
        RND_G,
        RND_H
    } round_t;

    localparam logic [0:47][3:0] MSG_IDX = {
        4'd0, 4'd1, 4'd2,  4'd3,  4'd4, 4'd5,  4'd6, 4'd7,
        4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15,
        4'd0, 4'd4, 4'd8,  4'd12, 4'd1, 4'd5,  4'd9, 4'd13,
        4'd2, 4'd6, 4'd10, 4'd14, 4'd3, 4'd7,  4'd11, 4'd15,
        4'd0, 4'd8, 4'd4,  4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
        4'd1, 4'd9, 4'd5,  4'd13, 4'd3, 4'd11, 4'd7, 4'd15
    };

    localparam logic [0:47][4:0] SHIFT = {
        5'd3, 5'd7, 5'd11, 5'd19, 5'd3, 5'd7, 5'd11, 5'd19,
        5'd3, 5'd7, 5'd11, 5'd19, 5'd3, 5'd7, 5'd11, 5'd19,
        5'd3, 5'd5, 5'd9,  5'd13, 5'd3, 5'd5, 5'd9,  5'd13,
        5'd3, 5'd5, 5'd9,  5'd13, 5'd3, 5'd5, 5'd9,  5'd13,
        5'd3, 5'd9, 5'd11, 5'd15, 5'd3, 5'd9, 5'd11, 5'd15,
        5'd3, 5'd9, 5'd11, 5'd15, 5'd3, 5'd9, 5'd11, 5'd15
    };

    function automatic round_t round_of(input logic [5:0] step);
        if (step < 6'd16)
            return RND_F;
        else if (step < 6'd32)
            return RND_G;
        else
            return RND_H;
    endfunction

endpackage

// File: rtl/md4_step.sv
// One MD4 step: new b = rotl(a + f(b,c,d) + x + K, s).
// Purely combinational.
module md4_step
    import md4_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [31:0] x,
    input  round_t      rnd,
    input  logic [4:0]  s,
    output logic [31:0] new_b
);

    logic [31:0] f;
    logic [31:0] k;
    logic [31:0] sum;
    logic [63:0] dbl;

    // Round function and constant, sum, then rotate left by s.
    always_comb begin
        f = '0;
        k = '0;
        unique case (rnd)
            RND_F: begin
                f = (b & c) | (~b & d);
                k = K_F;
            end
            RND_G: begin
                f = (b & c) | (b & d) | (c & d);
                k = K_G;
            end
            RND_H: begin
                f = b ^ c ^ d;
                k = K_H;
            end
            default: begin
                f = '0;
                k = '0;
            end
        endcase
        sum   = a + f + x + k;
        dbl   = {sum, sum} << s;
        new_b = dbl[63:32];
    end

endmodule

// File: rtl/md4_block.sv
// MD4 compression of one 512-bit block, one step per clock.
// Start on irdy rise; result 49 cycles later with ordy.
module md4_block
    import md4_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         irdy,
    input  logic [31:0]  in_a,
    input  logic [31:0]  in_b,
    input  logic [31:0]  in_c,
    input  logic [31:0]  in_d,
    input  logic [511:0] data,
    output logic         ordy,
    output logic [31:0]  out_a,
    output logic [31:0]  out_b,
    output logic [31:0]  out_c,
    output logic [31:0]  out_d
);

    state_t       state;
    logic         irdy_q;
    logic [5:0]   step;
    logic [31:0]  wa, wb, wc, wd;
    logic [31:0]  ca, cb, cc, cd;
    logic [511:0] x_q;

    logic         start;
    logic [5:0]   sidx;
    logic [3:0]   widx;
    logic [31:0]  xw;
    round_t       rnd;
    logic [4:0]   shamt;
    logic [31:0]  nb;

    assign start = irdy & ~irdy_q & (state != S_BUSY);
    assign sidx  = (step < LAST_STEP) ? step : 6'd0;
    assign widx  = MSG_IDX[sidx];
    assign xw    = x_q[{widx, 5'd0} +: 32];
    assign rnd   = round_of(sidx);
    assign shamt = SHIFT[sidx];

    md4_step u_step (
        .a     (wa),
        .b     (wb),
        .c     (wc),
        .d     (wd),
        .x     (xw),
        .rnd   (rnd),
        .s     (shamt),
        .new_b (nb)
    );

    // Control FSM, working registers and final chaining add.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            irdy_q <= 1'b0;
            step   <= '0;
            wa     <= '0;
            wb     <= '0;
            wc     <= '0;
            wd     <= '0;
            ca     <= '0;
            cb     <= '0;
            cc     <= '0;
            cd     <= '0;
            x_q    <= '0;
            ordy   <= 1'b0;
            out_a  <= '0;
            out_b  <= '0;
            out_c  <= '0;
            out_d  <= '0;
        end else begin
            irdy_q <= irdy;
            if (start) begin
                ca    <= in_a;
                cb    <= in_b;
                cc    <= in_c;
                cd    <= in_d;
                wa    <= in_a;
                wb    <= in_b;
                wc    <= in_c;
                wd    <= in_d;
                x_q   <= data;
                step  <= '0;
                ordy  <= 1'b0;
                state <= S_BUSY;
            end else begin
                unique case (state)
                    S_BUSY: begin
                        if (step == LAST_STEP) begin
                            out_a <= ca + wa;
                            out_b <= cb + wb;
                            out_c <= cc + wc;
                            out_d <= cd + wd;
                            ordy  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            wa   <= wd;
                            wb   <= nb;
                            wc   <= wb;
                            wd   <= wc;
                            step <= step + 6'd1;
                        end
                    end
                    S_IDLE: state <= S_IDLE;
                    S_DONE: state <= S_DONE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_md4_block.sv
// Self-checking bench for md4_block: known-answer and
// reference-model vectors, scoreboard, control corner cases.
module tb_md4_block;

    logic         clk;
    logic         rst_n;
    logic         irdy;
    logic [31:0]  in_a, in_b, in_c, in_d;
    logic [511:0] data;
    logic         ordy;
    logic [31:0]  out_a, out_b, out_c, out_d;

    md4_block dut (
        .clk   (clk),
        .rst_n (rst_n),
        .irdy  (irdy),
        .in_a  (in_a),
        .in_b  (in_b),
        .in_c  (in_c),
        .in_d  (in_d),
        .data  (data),
        .ordy  (ordy),
        .out_a (out_a),
        .out_b (out_b),
        .out_c (out_c),
        .out_d (out_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  a, b, c, d;
        logic [511:0] m;
        logic [127:0] exp;
    } vec_t;

    localparam int NVEC = 5;
    localparam logic [31:0] IA = 32'h67452301;
    localparam logic [31:0] IB = 32'hEFCDAB89;
    localparam logic [31:0] IC = 32'h98BADCFE;
    localparam logic [31:0] ID = 32'h10325476;

    localparam int RIDX [48] = '{
        0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
        0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15,
        0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15
    };
    localparam int RSH [12] = '{
        3, 7, 11, 19, 3, 5, 9, 13, 3, 9, 11, 15
    };

    vec_t         vecs [NVEC];
    logic [127:0] sb [$];
    int           n_vec;
    int           n_bad;
    logic         ordy_prev;

    task automatic chk(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] md4_ref(
        input logic [31:0] ia, ib, ic, id,
        input logic [511:0] m);
        logic [31:0] a, b, c, d, f, k, t, x;
        int r, s;
        a = ia; b = ib; c = ic; d = id;
        for (int i = 0; i < 48; i++) begin
            r = i / 16;
            case (r)
                0: begin f = (b & c) | (~b & d); k = 32'h0; end
                1: begin f = (b & c) | (b & d) | (c & d); k = 32'h5A827999; end
                default: begin f = b ^ c ^ d; k = 32'h6ED9EBA1; end
            endcase
            x = m[RIDX[i]*32 +: 32];
            s = RSH[r*4 + (i % 4)];
            t = a + f + x + k;
            t = (t << s) | (t >> (32 - s));
            a = d; d = c; c = b; b = t;
        end
        return {ia + a, ib + b, ic + c, id + d};
    endfunction

    // Scoreboard: compare each rising ordy against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && ordy && !ordy_prev) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_result: got %h want none",
                         {out_a, out_b, out_c, out_d});
            end else begin
                chk("result", {out_a, out_b, out_c, out_d},
                    sb.pop_front());
            end
        end
        ordy_prev = ordy;
    end

    // mode 0: short pulse; 1: irdy held high; 2: scramble inputs while busy
    task automatic wait_result(input int mode, input bit drop_chk);
        int lat;
        bit got;
        lat = 0;
        got = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1 && drop_chk)
                chk("ordy_drop", {127'd0, ordy}, 128'd0);
            if (mode == 0 && n == 2)
                irdy = 1'b0;
            if (mode == 2 && n >= 2 && n <= 40) begin
                in_a = $urandom; in_b = $urandom;
                in_c = $urandom; in_d = $urandom;
                for (int w = 0; w < 16; w++)
                    data[w*32 +: 32] = $urandom;
                irdy = 1'($urandom_range(0, 1));
            end
            if (mode == 2 && n == 41)
                irdy = 1'b0;
            if (ordy) begin
                lat = n - 1;
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: got no ordy want ordy in 49 cycles");
        end else begin
            chk("latency", 128'(lat), 128'd49);
        end
    endtask

    task automatic run_vec(input vec_t v, input int mode);
        irdy = 1'b0;
        @(negedge clk);
        in_a = v.a; in_b = v.b; in_c = v.c; in_d = v.d;
        data = v.m;
        irdy = 1'b1;
        sb.push_back(v.exp);
        wait_result(mode, 1'b1);
    endtask

    initial begin
        logic [127:0] held;
        bit stable;
        n_vec = 0;
        n_bad = 0;
        ordy_prev = 1'b0;
        rst_n = 1'b0;
        irdy = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; in_d = '0;
        data = '0;

        vecs[0].a = IA; vecs[0].b = IB; vecs[0].c = IC; vecs[0].d = ID;
        vecs[0].m = '0;
        vecs[0].m[31:0] = 32'h00000080;
        vecs[0].exp = {32'he0cfd631, 32'h31e96ad1,
                       32'hd7593cb7, 32'hc089c0e0};
        vecs[1].a = IA; vecs[1].b = IB; vecs[1].c = IC; vecs[1].d = ID;
        vecs[1].m = '0;
        vecs[1].m[31:0] = 32'h80636261;
        vecs[1].m[14*32 +: 32] = 32'h00000018;
        vecs[1].exp = {32'h7a0148a4, 32'h52d821af,
                       32'he80ac15f, 32'h9d72a67a};
        for (int i = 2; i < NVEC; i++) begin
            vecs[i].a = $urandom; vecs[i].b = $urandom;
            vecs[i].c = $urandom; vecs[i].d = $urandom;
            for (int w = 0; w < 16; w++)
                vecs[i].m[w*32 +: 32] = $urandom;
            vecs[i].exp = md4_ref(vecs[i].a, vecs[i].b, vecs[i].c,
                                  vecs[i].d, vecs[i].m);
        end

        repeat (3) @(negedge clk);
        chk("reset_ordy", {127'd0, ordy}, 128'd0);
        chk("reset_out", {out_a, out_b, out_c, out_d}, 128'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++)
            run_vec(vecs[i], 0);

        // Held-high irdy: one compression, result stays put.
        run_vec(vecs[0], 1);
        held = {out_a, out_b, out_c, out_d};
        stable = 1;
        repeat (60) begin
            @(negedge clk);
            if (!ordy || {out_a, out_b, out_c, out_d} !== held)
                stable = 0;
        end
        chk("hold_stable", {127'd0, stable}, 128'd1);

        // Second "abc" run straight out of DONE.
        run_vec(vecs[1], 0);

        // Inputs and irdy scrambled during BUSY.
        run_vec(vecs[1], 2);

        // Reset at step 20 aborts; irdy high across release restarts.
        irdy = 1'b0;
        @(negedge clk);
        in_a = vecs[0].a; in_b = vecs[0].b;
        in_c = vecs[0].c; in_d = vecs[0].d;
        data = vecs[0].m;
        irdy = 1'b1;
        repeat (21) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ordy", {127'd0, ordy}, 128'd0);
        chk("abort_out", {out_a, out_b, out_c, out_d}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(vecs[0].exp);
        wait_result(0, 1'b1);

        irdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_empty", 128'(sb.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/md4_block.md
MD4_BLOCK -- requirements
Module: md4_block

Interface
REQ-001 Parameters: none; the block is fixed to one 512-bit MD4 compression.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 irdy  input  1  start request; a 0->1 transition while idle or done starts a compression.
REQ-005 in_a, in_b, in_c, in_d  input  32 each  chaining values A..D, numeric words.
REQ-006 data  input  512  message block; word X[k] = data[32k+31:32k], k=0..15, already little-endian packed by the caller.
REQ-007 ordy  output  1  result valid; high while out_* hold a finished result.
REQ-008 out_a, out_b, out_c, out_d  output  32 each  chaining values after compression (A..D + round result).

Function
REQ-009 States: IDLE, BUSY (48 steps), DONE.
REQ-010 Start is detected when irdy=1 and its registered previous value is 0, in IDLE or DONE. On that edge (E0), capture in_a..in_d and all 16 data words, clear ordy, clear the step counter, and enter BUSY.
REQ-011 While BUSY, irdy and input changes are ignored; a held-high irdy does not restart.
REQ-012 Each BUSY edge E1..E48 executes one MD4 step: (a,b,c,d) <= (d, rotl32(a + f(b,c,d) + X[k] + K, s), b, c); all additions are mod 2^32.
REQ-013 Steps 0-15: f=(b&c)|(~b&d), K=0, k=0..15 in order, s cycles 3,7,11,19.
REQ-014 Steps 16-31: f=(b&c)|(b&d)|(c&d), K=0x5A827999, k=0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15, s cycles 3,5,9,13.
REQ-015 Steps 32-47: f=b^c^d, K=0x6ED9EBA1, k=0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, s cycles 3,9,11,15.
REQ-016 On edge E49, out_a..out_d <= captured in_a..in_d + working a..d (mod 2^32), ordy <= 1, state <= DONE. Latency: ordy visible 49 cycles after the start edge.
REQ-017 In DONE, ordy and out_* stay stable until the next start edge, which drops ordy to 0 on that edge.
REQ-018 No padding, length handling, or byte swapping inside the block.

Reset
REQ-019 While rst_n=0 at a clock edge: state <= IDLE, ordy <= 0, out_a..out_d <= 0, working registers and step counter <= 0, previous-irdy register <= 0.
REQ-020 Reset mid-BUSY aborts the computation with no result. If irdy is already high when rst_n is released, a start occurs on the first edge after release.

Structure
REQ-021 A shared package holds the MD4 IV (0x67452301, 0xEFCDAB89, 0x98BADCFE, 0x10325476), the round constants, and the 48-entry message-index and shift tables.
REQ-022 A combinational sub-module md4_step (inputs a,b,c,d,x,round,s; output the new b) is natural; md4_block holds the FSM, the registers, and the final add.

Verification
REQ-023 IV, data word0=0x00000080, all other words 0 (empty message) -> ordy after 49 cycles; out = e0cfd631, 31e96ad1, d7593cb7, c089c0e0 (MD4 "" = 31d6cfe0...c089c0).
REQ-024 IV, word0=0x80636261, word14=0x00000018, others 0 ("abc") -> out = 7a0148a4, 52d821af, e80ac15f, 9d72a67a.
REQ-025 irdy held high for 2 cycles, then also held high through the whole run -> exactly one compression; ordy stays high with the same outputs.
REQ-026 Second irdy pulse after DONE with the "abc" block -> ordy drops on the start edge and rises 49 cycles later with the "abc" result.
REQ-027 rst_n low at step 20 -> ordy=0 and outputs 0; after release, a fresh "" run gives the REQ-023 values.
REQ-028 Toggle in_* and data during BUSY -> result is unchanged from the values captured at start.
